uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Round-robin sharing of one UART TX (start/busy handshake) among
//             N_REQ requesters, one byte per grant, with a busy-rise watchdog.
//             Optional UART_ARB_LOCK_EN adds req_lock for multi-byte packets.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                      clock,
    input  logic                      resetb,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [N_REQ-1:0]          req_lock,
`endif
    output logic [N_REQ-1:0]          req_ack,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      active,
    output logic                      err_timeout,
    input  logic                      err_clr
);

    localparam int GRANT_W = $clog2(N_REQ);
    localparam int CNT_W   = $clog2(BUSY_TIMEOUT);

    localparam logic [CNT_W-1:0]   c_cnt_last = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [GRANT_W-1:0] c_last_rst = GRANT_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t               r_state,  w_state_nxt;
    logic [GRANT_W-1:0]   r_last,   w_last_nxt;
    logic [GRANT_W-1:0]   r_grant,  w_grant_nxt;
    logic [DATA_W-1:0]    r_data,   w_data_nxt;
    logic [N_REQ-1:0]     r_ack,    w_ack_nxt;
    logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
    logic                 r_start,  w_start_nxt;
    logic                 r_err,    w_err_nxt;
    logic                 r_active;
    logic                 w_err_set;

    logic                 w_found;
    logic [GRANT_W-1:0]   w_pick;
    logic [DATA_W-1:0]    w_pick_data;

`ifdef UART_ARB_LOCK_EN
    logic                 r_locked, w_locked_nxt;
    logic                 w_lock_on;

    assign w_lock_on = r_locked & req_lock[r_grant];
`endif

    function automatic logic [GRANT_W-1:0] f_wrap(input logic [GRANT_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return GRANT_W'(s);
    endfunction

    // Scan from the farthest candidate back so the nearest one after r_last wins.
    always_comb begin
        w_found     = 1'b0;
        w_pick      = '0;
        w_pick_data = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[f_wrap(r_last, k)]) begin
                w_found = 1'b1;
                w_pick  = f_wrap(r_last, k);
            end
        end
`ifdef UART_ARB_LOCK_EN
        if (w_lock_on) begin
            w_found = req[r_grant];
            w_pick  = r_grant;
        end
`endif
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick == GRANT_W'(i)) w_pick_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_last_nxt   = r_last;
        w_grant_nxt  = r_grant;
        w_data_nxt   = r_data;
        w_ack_nxt    = '0;
        w_cnt_nxt    = r_cnt;
        w_start_nxt  = r_start;
        w_err_set    = 1'b0;
`ifdef UART_ARB_LOCK_EN
        w_locked_nxt = r_locked;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef UART_ARB_LOCK_EN
                w_locked_nxt = w_lock_on;
`endif
                if (w_found && !tx_busy) begin
                    w_data_nxt        = w_pick_data;
                    w_grant_nxt       = w_pick;
                    w_last_nxt        = w_pick;
                    w_ack_nxt[w_pick] = 1'b1;
                    w_start_nxt       = 1'b1;
                    w_cnt_nxt         = '0;
                    w_state_nxt       = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_start_nxt = 1'b0;
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt == c_cnt_last) begin
                    // Byte is dropped: it was already acked to the requester.
                    w_start_nxt  = 1'b0;
                    w_err_set    = 1'b1;
                    w_state_nxt  = S_IDLE;
`ifdef UART_ARB_LOCK_EN
                    w_locked_nxt = 1'b0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt  = S_IDLE;
`ifdef UART_ARB_LOCK_EN
                    w_locked_nxt = req_lock[r_grant];
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_start_nxt = 1'b0;
            end
        endcase

        // A timeout in the same cycle as err_clr leaves the flag set.
        w_err_nxt = w_err_set ? 1'b1 : (err_clr ? 1'b0 : r_err);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state  <= S_IDLE;
            r_last   <= c_last_rst;
            r_grant  <= '0;
            r_data   <= '0;
            r_ack    <= '0;
            r_cnt    <= '0;
            r_start  <= 1'b0;
            r_err    <= 1'b0;
            r_active <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            r_locked <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_last   <= w_last_nxt;
            r_grant  <= w_grant_nxt;
            r_data   <= w_data_nxt;
            r_ack    <= w_ack_nxt;
            r_cnt    <= w_cnt_nxt;
            r_start  <= w_start_nxt;
            r_err    <= w_err_nxt;
            r_active <= (w_state_nxt != S_IDLE);
`ifdef UART_ARB_LOCK_EN
            r_locked <= w_locked_nxt;
`endif
        end
    end

    assign req_ack     = r_ack;
    assign tx_start    = r_start;
    assign tx_data     = r_data;
    assign grant_id    = r_grant;
    assign active      = r_active;
    assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Directed and randomized bench for uart_tx_arbiter with a
//             reference model and a simple UART TX responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic        clock    = 1'b0;
    logic        resetb   = 1'b0;
    logic [3:0]  req      = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy  = 1'b0;
    logic [1:0]  grant_id;
    logic        active;
    logic        err_timeout;
    logic        err_clr  = 1'b0;
`ifdef UART_ARB_LOCK_EN
    logic [3:0]  req_lock = '0;
`endif

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(8), .BUSY_TIMEOUT(TO)) dut (
        .clock(clock), .resetb(resetb), .req(req), .req_data(req_data),
`ifdef UART_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .active(active),
        .err_timeout(err_timeout), .err_clr(err_clr)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model: transfer-level view ----------------
    int         m_phase  = 0;      // 0 no transfer, 1 start issued, 2 UART sending
    int         m_last   = N - 1;
    int         m_wait   = 0;
    bit         m_locked = 1'b0;
    bit         m_seterr;
    int         m_g;
    logic [3:0] e_ack    = '0;
    logic       e_start  = 1'b0;
    logic [7:0] e_data   = '0;
    logic [1:0] e_gid    = '0;
    logic       e_err    = 1'b0;
    logic       e_active = 1'b0;

    always @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            m_phase = 0; m_last = N - 1; m_wait = 0; m_locked = 1'b0;
            e_ack = '0; e_start = 1'b0; e_data = '0; e_gid = '0;
            e_err = 1'b0; e_active = 1'b0;
        end else begin
            m_seterr = 1'b0;
            e_ack    = '0;
            if (m_phase == 0) begin
                m_g = -1;
`ifdef UART_ARB_LOCK_EN
                if (m_locked && req_lock[m_last]) begin
                    if (req[m_last]) m_g = m_last;
                end else begin
                    m_locked = 1'b0;
                    for (int k = 1; k <= N; k++)
                        if (m_g < 0 && req[(m_last + k) % N]) m_g = (m_last + k) % N;
                end
`else
                for (int k = 1; k <= N; k++)
                    if (m_g < 0 && req[(m_last + k) % N]) m_g = (m_last + k) % N;
`endif
                if (m_g >= 0 && !tx_busy) begin
                    e_ack   = 4'(1 << m_g);
                    e_start = 1'b1;
                    e_data  = 8'(req_data >> (m_g * 8));
                    e_gid   = 2'(m_g);
                    m_last  = m_g;
                    m_phase = 1;
                    m_wait  = 0;
                end
            end else if (m_phase == 1) begin
                if (tx_busy) begin
                    e_start = 1'b0; m_phase = 2;
                end else if (m_wait == TO - 1) begin
                    e_start = 1'b0; m_seterr = 1'b1; m_phase = 0; m_locked = 1'b0;
                end else begin
                    m_wait++;
                end
            end else begin
                if (!tx_busy) begin
                    m_phase = 0;
`ifdef UART_ARB_LOCK_EN
                    m_locked = req_lock[m_last];
`endif
                end
            end
            if (m_seterr)     e_err = 1'b1;
            else if (err_clr) e_err = 1'b0;
            e_active = (m_phase != 0);
        end
    end

    always @(negedge clock) begin
        chk("cyc_ack",    32'(req_ack),     32'(e_ack));
        chk("cyc_start",  32'(tx_start),    32'(e_start));
        chk("cyc_data",   32'(tx_data),     32'(e_data));
        chk("cyc_gid",    32'(grant_id),    32'(e_gid));
        chk("cyc_active", 32'(active),      32'(e_active));
        chk("cyc_err",    32'(err_timeout), 32'(e_err));
    end

    // ---------------- UART TX responder ----------------
    int         tx_mode     = 0;   // 0 responsive, 1 never busy, 2 foreign busy
    bit         tx_hold     = 1'b0;
    bit         tx_rand_mute = 1'b0;
    bit         tx_armed    = 1'b0;
    bit         tx_mute     = 1'b0;
    int         tx_dly      = 0;
    int         tx_rise     = 0;
    int         tx_len      = 0;
    logic [7:0] sent_q[$];

    always @(posedge clock) begin
        #1;
        if (tx_mode == 2) begin
            tx_busy = 1'b1;
        end else if (tx_mode == 1) begin
            tx_busy = 1'b0;
        end else if (tx_busy) begin
            if (!tx_hold) begin
                if (tx_len == 0) tx_busy = 1'b0;
                else tx_len--;
            end
        end else if (tx_start) begin
            if (!tx_armed) begin
                tx_armed = 1'b1;
                tx_dly   = 0;
                tx_rise  = $urandom_range(0, 3);
                tx_mute  = tx_rand_mute && ($urandom_range(0, 11) == 0);
            end
            if (!tx_mute) begin
                if (tx_dly >= tx_rise) begin
                    tx_busy  = 1'b1;
                    tx_len   = $urandom_range(0, 5);
                    tx_armed = 1'b0;
                    sent_q.push_back(tx_data);
                end else begin
                    tx_dly++;
                end
            end
        end else begin
            tx_armed = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_grant(input string nm, output int g);
        g = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (req_ack != 0) begin
                for (int b = 0; b < N; b++) if (req_ack[b]) g = b;
                return;
            end
        end
        chk({nm, "_no_grant"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (!active && !tx_busy) return;
        end
        chk("idle_wait", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clock); resetb = 1'b0;
        @(negedge clock); resetb = 1'b1;
    endtask

    int g;
    int cnt;

    initial begin
        // Reset values
        repeat (2) @(negedge clock);
        chk("rst_ack",    32'(req_ack),     32'd0);
        chk("rst_start",  32'(tx_start),    32'd0);
        chk("rst_data",   32'(tx_data),     32'd0);
        chk("rst_gid",    32'(grant_id),    32'd0);
        chk("rst_active", 32'(active),      32'd0);
        chk("rst_err",    32'(err_timeout), 32'd0);
        resetb = 1'b1;

        // Single request, one-cycle latency
        @(negedge clock);
        req = 4'b0100; req_data = 32'h003D_0000;
        @(negedge clock);
        chk("single_start", 32'(tx_start), 32'd1);
        chk("single_data",  32'(tx_data),  32'h3D);
        chk("single_gid",   32'(grant_id), 32'd2);
        chk("single_ack",   32'(req_ack),  32'b0100);
        req = 4'b0000;
        wait_idle();

        // All four pending after reset: served 0,1,2,3
        do_reset();
        sent_q.delete();
        req = 4'b1111; req_data = 32'h4433_2211;
        for (int k = 0; k < 4; k++) begin
            wait_grant("rr4", g);
            if (g >= 0) req[g] = 1'b0;
        end
        wait_idle();
        chk("rr4_count", 32'(sent_q.size()), 32'd4);
        if (sent_q.size() >= 4) begin
            chk("rr4_b0", 32'(sent_q[0]), 32'h11);
            chk("rr4_b1", 32'(sent_q[1]), 32'h22);
            chk("rr4_b2", 32'(sent_q[2]), 32'h33);
            chk("rr4_b3", 32'(sent_q[3]), 32'h44);
        end

        // Wrap-around after grant 1
        req = 4'b0010; req_data = 32'h0000_5A00;
        wait_grant("wrap_a", g); chk("wrap_first", 32'(g), 32'd1);
        req = 4'b0000; wait_idle();
        req = 4'b0011; req_data = 32'h0000_B2A1;
        wait_grant("wrap_b", g); chk("wrap_to_0", 32'(g), 32'd0);
        req[0] = 1'b0;
        wait_grant("wrap_c", g); chk("wrap_then_1", 32'(g), 32'd1);
        req = 4'b0000; wait_idle();

        // Watchdog: TX never goes busy
        tx_mode = 1;
        req = 4'b0001; req_data = 32'h0000_00C7;
        wait_grant("to", g);
        req = 4'b0000;
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (tx_start) cnt++;
            else break;
        end
        chk("to_start_len", 32'(cnt),         32'd16);
        chk("to_err_set",   32'(err_timeout), 32'd1);
        chk("to_idle",      32'(active),      32'd0);
        err_clr = 1'b1;
        @(negedge clock); err_clr = 1'b0;
        chk("to_err_clr",   32'(err_timeout), 32'd0);
        tx_mode = 0;

        // Foreign busy blocks arbitration
        tx_len = 0; tx_mode = 2;
        repeat (2) @(negedge clock);
        req = 4'b0001; req_data = 32'h0000_0077;
        repeat (5) @(negedge clock);
        chk("foreign_no_start", 32'(tx_start), 32'd0);
        tx_mode = 0;
        wait_grant("foreign", g); chk("foreign_grant", 32'(g), 32'd0);
        req = 4'b0000; wait_idle();

        // Asynchronous reset during the UART-sending phase
        tx_hold = 1'b1;
        req = 4'b0100; req_data = 32'h0066_0000;
        wait_grant("ar", g);
        req = 4'b0000;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (tx_busy && active && !tx_start) break;
        end
        @(posedge clock); #3;
        resetb = 1'b0;
        #1;
        chk("ar_start",  32'(tx_start), 32'd0);
        chk("ar_gid",    32'(grant_id), 32'd0);
        chk("ar_active", 32'(active),   32'd0);
        chk("ar_data",   32'(tx_data),  32'd0);
        @(negedge clock); resetb = 1'b1; tx_hold = 1'b0;
        req = 4'b1111; req_data = 32'hD4C3_B2A1;
        wait_grant("ar_next", g); chk("ar_next_grant", 32'(g), 32'd0);
        req = 4'b0000; wait_idle();

`ifdef UART_ARB_LOCK_EN
        // Locked packet: requester 1 keeps the channel for three bytes
        do_reset();
        req_lock = 4'b0010; req = 4'b0010; req_data = 32'h0000_E1F0;
        wait_grant("lk1", g); chk("lk_g1", 32'(g), 32'd1);
        req[0] = 1'b1;
        wait_grant("lk2", g); chk("lk_g2", 32'(g), 32'd1);
        wait_grant("lk3", g); chk("lk_g3", 32'(g), 32'd1);
        req[1] = 1'b0; req_lock = 4'b0000;
        wait_grant("lk4", g); chk("lk_g4", 32'(g), 32'd0);
        req = 4'b0000; wait_idle();
`endif

        // Randomized traffic with occasional silent transmitter and err_clr
        tx_rand_mute = 1'b1;
        repeat (800) begin
            @(posedge clock); #2;
            for (int i = 0; i < N; i++) begin
                if (req_ack[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    req_data[i*8 +: 8] = 8'($urandom);
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        req_data[i*8 +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    req[i] = 1'b0;
                end
            end
            err_clr = ($urandom_range(0, 19) == 0);
        end
        req = 4'b0000; err_clr = 1'b0; tx_rand_mute = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout at %0t: got running expected finished", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
